// File: rtl/pipe_hazard_ctrl.sv
// Hazard/redirect sequencer: stage enables, flushes and PC select.
// Optional perf counters (stallCnt, flushCnt) under PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int JALR_TIMEOUT = 4
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        flushReq,
  input  logic        holdReq,
  input  logic        branchReq,
  input  logic        bypassReq,
  input  logic [31:0] PCnextIn,
  input  logic        loadUse,
  output logic        pcWrite,
  output logic        pcSel,
  output logic [31:0] pcTarget,
  output logic        enIFID,
  output logic        enIDEXE,
  output logic        flushIFID,
  output logic        flushIDEXE,
  output logic [1:0]  state,
  output logic        jalrErr
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stallCnt,
  output logic [31:0] flushCnt
`endif
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_WAIT   = 2'd2,
    S_SQUASH = 2'd3
  } st_t;

  localparam int CW = $clog2(JALR_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(JALR_TIMEOUT - 1);

  st_t st;
  st_t st_nxt;
  logic [CW-1:0] cnt;

  logic take_exe;
  logic take_lu;
  logic take_hold;
  logic take_br;
  logic tmo;

  // Request decode: which event the current state accepts this cycle
  always_comb begin
    take_exe  = 1'b0;
    take_lu   = 1'b0;
    take_hold = 1'b0;
    take_br   = 1'b0;
    tmo       = 1'b0;
    unique case (st)
      S_BOOT: ;
      S_RUN: begin
        take_exe  = flushReq;
        take_lu   = !flushReq && loadUse;
        take_hold = !flushReq && !loadUse && holdReq;
        take_br   = !flushReq && !loadUse && !holdReq
                    && branchReq;
      end
      S_WAIT: begin
        take_exe = flushReq && bypassReq;
        tmo      = !take_exe && (cnt == TMO_LAST);
      end
      S_SQUASH: take_exe = flushReq;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      st      <= S_BOOT;
      cnt     <= '0;
      jalrErr <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= (st == S_WAIT) ? cnt + CW'(1) : '0;
      jalrErr <= jalrErr | tmo;
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_BOOT: st_nxt = S_RUN;
      S_RUN: begin
        if (take_exe || take_br)
          st_nxt = S_SQUASH;
        else if (take_hold)
          st_nxt = S_WAIT;
        else
          st_nxt = S_RUN;
      end
      S_WAIT: begin
        if (take_exe)
          st_nxt = S_SQUASH;
        else if (tmo)
          st_nxt = S_RUN;
        else
          st_nxt = S_WAIT;
      end
      S_SQUASH:
        st_nxt = take_exe ? S_SQUASH : S_RUN;
    endcase
  end

  always_comb begin
    pcWrite    = 1'b0;
    pcSel      = 1'b0;
    pcTarget   = '0;
    enIFID     = 1'b0;
    enIDEXE    = 1'b0;
    flushIFID  = 1'b1;
    flushIDEXE = 1'b1;
    if (take_exe) begin
      pcWrite  = 1'b1;
      pcSel    = 1'b1;
      pcTarget = PCnextIn;
      enIFID   = 1'b1;
      enIDEXE  = 1'b1;
    end else begin
      unique case (st)
        S_BOOT: ;
        S_RUN: begin
          flushIFID  = 1'b0;
          flushIDEXE = 1'b0;
          enIDEXE    = 1'b1;
          if (take_lu) begin
            flushIDEXE = 1'b1;
          end else if (take_hold) begin
            enIFID = 1'b0;
          end else if (take_br) begin
            pcWrite   = 1'b1;
            pcSel     = 1'b1;
            pcTarget  = PCnextIn;
            enIFID    = 1'b1;
            flushIFID = 1'b1;
          end else begin
            pcWrite = 1'b1;
            enIFID  = 1'b1;
          end
        end
        S_WAIT: begin
          enIDEXE   = 1'b1;
          flushIFID = 1'b0;
        end
        S_SQUASH: begin
          pcWrite    = 1'b1;
          enIFID     = 1'b1;
          enIDEXE    = 1'b1;
          flushIDEXE = 1'b0;
        end
      endcase
    end
  end

  assign state = st;

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcWrite && st != S_BOOT)
        stallCnt <= stallCnt + 32'd1;
      if (pcSel)
        flushCnt <= flushCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against an action-level model.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 4;

  localparam int A_BOOT = 0;
  localparam int A_EXE  = 1;
  localparam int A_LU   = 2;
  localparam int A_HOLD = 3;
  localparam int A_BR   = 4;
  localparam int A_WAIT = 5;
  localparam int A_SQ   = 6;
  localparam int A_RUN  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flushReq = 1'b0;
  logic holdReq = 1'b0;
  logic branchReq = 1'b0;
  logic bypassReq = 1'b0;
  logic loadUse = 1'b0;
  logic [31:0] PCnextIn = '0;

  logic pcWrite, pcSel, enIFID, enIDEXE;
  logic flushIFID, flushIDEXE, jalrErr;
  logic [31:0] pcTarget;
  logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt;
`endif

  int errors = 0;
  int checks = 0;

  int m_mode = 0;
  int m_wait = 0;
  logic m_err = 1'b0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  logic [40:0] got;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.JALR_TIMEOUT(TMO)) dut (
    .Clock(clk),
    .nReset(rst_n),
    .flushReq(flushReq),
    .holdReq(holdReq),
    .branchReq(branchReq),
    .bypassReq(bypassReq),
    .PCnextIn(PCnextIn),
    .loadUse(loadUse),
    .pcWrite(pcWrite),
    .pcSel(pcSel),
    .pcTarget(pcTarget),
    .enIFID(enIFID),
    .enIDEXE(enIDEXE),
    .flushIFID(flushIFID),
    .flushIDEXE(flushIDEXE),
    .state(state),
    .jalrErr(jalrErr)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stallCnt(stallCnt),
    .flushCnt(flushCnt)
`endif
  );

  assign got = {state, jalrErr, pcWrite, pcSel, pcTarget,
                enIFID, enIDEXE, flushIFID, flushIDEXE};

  // What the sequencer should do this cycle, by the priority rules
  function automatic int action();
    int a;
    a = A_RUN;
    if (m_mode == 0)
      a = A_BOOT;
    else if (m_mode == 2)
      a = (flushReq && bypassReq) ? A_EXE : A_WAIT;
    else if (m_mode == 3)
      a = flushReq ? A_EXE : A_SQ;
    else if (flushReq)
      a = A_EXE;
    else if (loadUse)
      a = A_LU;
    else if (holdReq)
      a = A_HOLD;
    else if (branchReq)
      a = A_BR;
    return a;
  endfunction

  function automatic logic [40:0] expect_vec();
    logic [5:0] t;
    logic [31:0] tgt;
    case (action())
      A_BOOT:  t = 6'b000011;
      A_EXE:   t = 6'b111111;
      A_LU:    t = 6'b000101;
      A_HOLD:  t = 6'b000100;
      A_BR:    t = 6'b111110;
      A_WAIT:  t = 6'b000101;
      A_SQ:    t = 6'b101110;
      default: t = 6'b101100;
    endcase
    tgt = t[4] ? PCnextIn : 32'h0;
    return {2'(m_mode), m_err, t[5], t[4], tgt, t[3:0]};
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int a;
    if (!rst_n) begin
      m_mode  <= 0;
      m_wait  <= 0;
      m_err   <= 1'b0;
      m_stall <= '0;
      m_flush <= '0;
    end else begin
      a = action();
      if (a == A_LU || a == A_HOLD || a == A_WAIT)
        m_stall <= m_stall + 32'd1;
      if (a == A_EXE || a == A_BR)
        m_flush <= m_flush + 32'd1;
      case (a)
        A_EXE, A_BR: m_mode <= 3;
        A_HOLD: begin
          m_mode <= 2;
          m_wait <= 0;
        end
        A_WAIT: begin
          if (m_wait + 1 >= TMO) begin
            m_err  <= 1'b1;
            m_mode <= 1;
            m_wait <= 0;
          end else begin
            m_wait <= m_wait + 1;
          end
        end
        default: m_mode <= 1;
      endcase
    end
  end

  task automatic drive(input logic f, input logic h,
                       input logic b, input logic by,
                       input logic lu, input logic [31:0] pc);
    flushReq  = f;
    holdReq   = h;
    branchReq = b;
    bypassReq = by;
    loadUse   = lu;
    PCnextIn  = pc;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (got !== {2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0011}) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", got,
               {2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0011});
    end
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (state !== 2'd0 || flushIFID !== 1'b1 ||
        flushIDEXE !== 1'b1 || pcWrite !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle0: got %h", got);
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (state !== 2'd1 || pcWrite !== 1'b1 || pcSel !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle1: got %h", got);
    end
    checks++;
    if (got !== expect_vec()) begin
      errors++;
      $display("FAIL idle_model: got %h required %h", got, expect_vec());
    end
    tick();
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 0, 0, 32'h100);
    checks++;
    if (pcSel !== 1'b1 || pcTarget !== 32'h100 || flushIFID !== 1'b1) begin
      errors++;
      $display("FAIL branch_req: got %h", got);
    end
    checks++;
    if (got !== expect_vec()) begin
      errors++;
      $display("FAIL branch_model: got %h required %h", got, expect_vec());
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (state !== 2'd3 || flushIFID !== 1'b1 || pcSel !== 1'b0) begin
      errors++;
      $display("FAIL branch_squash: got %h", got);
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (state !== 2'd1 || flushIFID !== 1'b0) begin
      errors++;
      $display("FAIL branch_back_to_run: got %h", got);
    end
    tick();
  endtask

  task automatic test_load_use();
    drive(0, 0, 0, 0, 1, 32'h0);
    checks++;
    if (pcWrite !== 1'b0 || enIFID !== 1'b0 || flushIDEXE !== 1'b1 ||
        enIDEXE !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL load_use_stall: got %h", got);
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (pcWrite !== 1'b1 || enIFID !== 1'b1 || flushIDEXE !== 1'b0) begin
      errors++;
      $display("FAIL load_use_release: got %h", got);
    end
    tick();
  endtask

  task automatic test_jalr_resolve();
    drive(0, 1, 0, 0, 0, 32'h0);
    checks++;
    if (pcWrite !== 1'b0 || enIFID !== 1'b0 || enIDEXE !== 1'b1) begin
      errors++;
      $display("FAIL jalr_hold: got %h", got);
    end
    tick();
    drive(1, 0, 0, 1, 0, 32'h2004);
    checks++;
    if (state !== 2'd2 || pcSel !== 1'b1 || pcTarget !== 32'h2004) begin
      errors++;
      $display("FAIL jalr_resolve: got %h", got);
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (state !== 2'd3) begin
      errors++;
      $display("FAIL jalr_squash: got %0d required 3", state);
    end
    tick();
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (state !== 2'd1 || jalrErr !== 1'b0) begin
      errors++;
      $display("FAIL jalr_done: got %h", got);
    end
    tick();
  endtask

  task automatic test_jalr_timeout();
    drive(0, 1, 0, 0, 0, 32'h0);
    tick();
    for (int i = 0; i < TMO; i++) begin
      drive(0, 0, 0, 0, 0, 32'h0);
      checks++;
      if (state !== 2'd2 || flushIDEXE !== 1'b1 || jalrErr !== 1'b0) begin
        errors++;
        $display("FAIL jalr_wait_%0d: got %h", i, got);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (state !== 2'd1 || jalrErr !== 1'b1) begin
      errors++;
      $display("FAIL jalr_timeout: got %h", got);
    end
    tick();
  endtask

  task automatic test_async_reset();
    drive(0, 1, 0, 0, 0, 32'h0);
    tick();
    drive(1, 0, 0, 1, 0, 32'h80);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got !== {2'd0, 1'b0, 1'b0, 1'b0, 32'h0, 4'b0011}) begin
      errors++;
      $display("FAIL async_reset: got %h", got);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 32'h0);
    checks++;
    if (got !== expect_vec() || state !== 2'd0) begin
      errors++;
      $display("FAIL reset_boot: got %h required %h", got, expect_vec());
    end
    tick();
  endtask

  task automatic test_flush_vs_loaduse();
    drive(1, 0, 0, 0, 1, 32'h40);
    checks++;
    if (pcWrite !== 1'b1 || pcSel !== 1'b1 || pcTarget !== 32'h40 ||
        enIFID !== 1'b1) begin
      errors++;
      $display("FAIL flush_beats_loaduse: got %h", got);
    end
    tick();
`ifdef PIPE_PERF_CNT_EN
    checks++;
    if (flushCnt !== 32'd1 || stallCnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_counts: got flush=%0d stall=%0d required 1 0",
               flushCnt, stallCnt);
    end
`endif
    drive(0, 0, 0, 0, 0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 5) == 0, {$urandom_range(0, 32'h3fff), 2'b00});
      checks++;
      if (got !== expect_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h required %h", i, got, expect_vec());
      end
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (stallCnt !== m_stall || flushCnt !== m_flush) begin
        errors++;
        $display("FAIL random_perf_%0d: got %0d/%0d required %0d/%0d",
                 i, stallCnt, flushCnt, m_stall, m_flush);
      end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load_use();
    test_jalr_resolve();
    test_jalr_timeout();
    test_async_reset();
    test_flush_vs_loaduse();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
